// File: rtl/serial_addsub_pkg.sv
// ---------------------------------------------------------------------------
// serial_addsub_pkg
// Shared types and helpers for the digit-serial adder/subtractor.
//   state_t       : controller states (IDLE, RUN, DONE)
//   MODE_ADD/SUB  : encoding of the 'sub' request bit
//   num_digits()  : number of digits per operand (WIDTH / DIGIT)
//   count_width() : digit counter width, at least one bit
// Optional feature macro used by the block: SERIAL_ADDSUB_OVF_EN
// ---------------------------------------------------------------------------
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit operation still needs a one-bit counter.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// ---------------------------------------------------------------------------
// digit_adder
// Combinational DIGIT-bit ripple-carry adder used once per clock by
// serial_addsub.
// Ports:
//   x, y      in  DIGIT  addend digits
//   ci        in  1      carry in
//   s         out DIGIT  sum digit
//   co        out 1      carry out of the digit MSB
//   c_msb_in  out 1      carry into the digit MSB (overflow detection)
// ---------------------------------------------------------------------------
module digit_adder
    import serial_addsub_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    // Ripple the carry through the digit, capturing the carry entering the MSB.
    always_comb begin
        logic c_v;
        c_v      = ci;
        s        = {DIGIT{1'b0}};
        c_msb_in = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb_in = c_v;
            end else begin
                c_msb_in = c_msb_in;
            end
            s[i] = x[i] ^ y[i] ^ c_v;
            c_v  = (x[i] & y[i]) | (x[i] & c_v) | (y[i] & c_v);
        end
        co = c_v;
    end

endmodule

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first,
// start/done handshake. An operation takes N = WIDTH/DIGIT RUN cycles plus
// one DONE cycle; subtraction adds the inverted B with carry-in 1.
// Optional feature: define SERIAL_ADDSUB_OVF_EN to add the signed overflow
// output 'ovf'.
// Ports:
//   clk    in   1      clock, rising edge
//   reset  in   1      asynchronous, active-high reset
//   start  in   1      request, sampled only while ready=1
//   sub    in   1      0: a+b, 1: a-b (latched with the operands)
//   a, b   in   WIDTH  operands, latched on accepted start
//   ready  out  1      high in IDLE
//   busy   out  1      high in RUN
//   done   out  1      one-cycle pulse, results valid from this cycle
//   sum    out  WIDTH  result, held until the next accepted start
//   cout   out  1      final carry (sub: 1 = no borrow)
//   ovf    out  1      signed overflow (SERIAL_ADDSUB_OVF_EN only)
// ---------------------------------------------------------------------------
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = count_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_digit_check
            $error("serial_addsub: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sub_r;
    logic             carry_r;
    logic [CW-1:0]    count_r;
    logic             accept_s;
    logic             last_s;
    logic [DIGIT-1:0] x_s;
    logic [DIGIT-1:0] y_s;
    logic [DIGIT-1:0] s_s;
    logic             co_s;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             c_msb_s;
`else
    logic             c_msb_unused_s;
`endif

    assign accept_s = (state_r == IDLE) && start;
    assign last_s   = (state_r == RUN) && (count_r == CNT_LAST);

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready   <= (state_next_s == IDLE);
            busy    <= (state_next_s == RUN);
            done    <= (state_next_s == DONE);
        end
    end

    // Operand latch; a start outside IDLE never reloads the operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            sub_r <= MODE_ADD;
        end else if (accept_s) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
        end else begin
            a_r   <= a_r;
            b_r   <= b_r;
            sub_r <= sub_r;
        end
    end

    // Select the current digit; B is inverted digit by digit when subtracting.
    always_comb begin
        x_s = {DIGIT{1'b0}};
        y_s = {DIGIT{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (count_r == CW'(i)) begin
                x_s = a_r[i*DIGIT +: DIGIT];
                y_s = b_r[i*DIGIT +: DIGIT] ^ {DIGIT{sub_r}};
            end else begin
                x_s = x_s;
                y_s = y_s;
            end
        end
    end

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit_adder (
        .x        (x_s),
        .y        (y_s),
        .ci       (carry_r),
        .s        (s_s),
        .co       (co_s),
`ifdef SERIAL_ADDSUB_OVF_EN
        .c_msb_in (c_msb_s)
`else
        .c_msb_in (c_msb_unused_s)
`endif
    );

    // Serial datapath: carry flop, digit counter, result digits and final carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_r <= 1'b0;
            count_r <= {CW{1'b0}};
            sum     <= {WIDTH{1'b0}};
            cout    <= 1'b0;
        end else if (accept_s) begin
            // Carry-in of 1 completes the two's complement of B.
            carry_r <= (sub == MODE_SUB);
            count_r <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            carry_r <= co_s;
            // Counter parks on the last digit instead of wrapping.
            count_r <= last_s ? count_r : count_r + CW'(1'b1);
            for (int i = 0; i < N; i++) begin
                if (count_r == CW'(i)) begin
                    sum[i*DIGIT +: DIGIT] <= s_s;
                end else begin
                    sum[i*DIGIT +: DIGIT] <= sum[i*DIGIT +: DIGIT];
                end
            end
            if (last_s) begin
                cout <= co_s;
            end else begin
                cout <= cout;
            end
        end else begin
            carry_r <= carry_r;
            count_r <= count_r;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (last_s) begin
            ovf <= c_msb_s ^ co_s;
        end else begin
            ovf <= ovf;
        end
    end
`endif

endmodule
